alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised, slice-serial successor to the 64-bit ALU. It computes NOR, XOR, ADD or SUB on WIDTH-bit operands, SLICE bits per clock, and chains the carry between slices in a register. A start/busy/done handshake connects it to a sequencer. Trading latency for area lets wide datapaths reuse one narrow adder slice.

## Interface
- WIDTH, 64: operand and result width. Must be an exact multiple of SLICE.
- SLICE, 16: bits processed per cycle. N = WIDTH/SLICE gives the number of slice cycles. SLICE = WIDTH is legal and gives N = 1.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only when busy = 0.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- op  input  2  operation select; captured on the accepting edge.
- cin  input  1  carry in; captured on the accepting edge.
- busy  output  1  high while slices are being processed.
- done  output  1  single-cycle pulse; s, cout and ovf are valid.
- s  output  WIDTH  result; held until the next accepted start or reset.
- cout  output  1  final carry for ADD/SUB; 0 for logic ops.
- ovf  output  1  signed overflow for ADD/SUB; 0 for logic ops.

## Operation
- op encoding:
  - 00: s = ~(a|b)
  - 01: s = a^b
  - 10: {cout,s} = a + b + cin
  - 11: {cout,s} = a + ~b + cin. Subtraction therefore requires cin = 1.
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE or DONE with start = 1:
  - Capture a, b, op, cin into operand registers.
  - Set carry register to cin and slice index to 0.
  - Go to RUN.
- IDLE or DONE with start = 0: go to, or stay in, IDLE.
- RUN, each cycle:
  - Operate on slice idx, bits [idx*SLICE +: SLICE].
  - Write the slice result into s and the slice carry-out into the carry register. For logic ops the carry register is held at 0.
  - Increment idx.
  - If idx = N-1, go to DONE.
- Final RUN cycle:
  - cout gets the final carry for op 1x, else 0.
  - ovf gets the carry into the MSB XOR the carry out of the MSB, for op 1x; else 0.
- DONE lasts exactly one cycle.
- start while busy = 1 is ignored; the captured operands are unaffected.
- Slice index register width is ceil(log2(N)), minimum 1 bit. It never wraps past N-1.
- Reset values:
  - busy, done, cout, ovf = 0
  - s = 0
  - state = IDLE
  - idx and the carry register = 0
- Reset mid-operation: the next edge with rst_n = 0 aborts the operation. All outputs return to reset values; no done pulse is produced.
- rst_n = 0 and start = 1 on the same edge: reset wins and start is dropped.

## Timing
- Define the accepting edge as E0. busy = 1 after E0 through the edge that completes the last slice.
- done = 1 after edge E0+N, for exactly one cycle. busy = 0 in that cycle. Latency is N cycles, 4 at the defaults.
- Back-to-back: start = 1 during the done cycle is accepted. Throughput is one result per N+1 cycles.
- s is written slice-by-slice during RUN, so intermediate values are visible. s is guaranteed only while done = 1, and until the next accepted start.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Defaults (64/16), op = 10, a = 64'hFFFF_FFFF_FFFF_FFFF, b = 0, cin = 0 -> done 4 cycles after start, s = 64'hFFFF_FFFF_FFFF_FFFF, cout = 0, ovf = 0. Same operands with cin = 1 -> s = 0, cout = 1, ovf = 0. The carry must ripple across all four slice boundaries.
- op = 11, cin = 1:
  - a = 5, b = 7 -> s = 64'hFFFF_FFFF_FFFF_FFFE, cout = 0.
  - a = 64'h8000_0000_0000_0000, b = 1 -> s = 64'h7FFF_FFFF_FFFF_FFFF, ovf = 1, cout = 1.
- Logic ops:
  - op = 00, a = 64'hF0F0_0000_0000_0000, b = 64'h0F00_0000_0000_00FF -> s = 64'h000F_FFFF_FFFF_FF00, cout = 0.
  - op = 01 on the same operands -> s = 64'hFFF0_0000_0000_00FF.
- Handshake:
  - start held high for 10 cycles -> first result done at +4, a second operation accepted in the done cycle and done at +9.
  - Operands changed while busy -> results reflect the captured values only.
- Reset: rst_n = 0 at the second RUN cycle -> next cycle busy = 0, s = 0, cout = 0, no done pulse. A fresh start then completes normally.
- Parameter sweep: SLICE = 64 (N = 1) and WIDTH = 32 / SLICE = 8. Random ADD/SUB/NOR/XOR against a reference model -> s, cout and ovf all match. done comes N cycles after start.

Source files
------------

// File: rtl/alu_multicycle.sv
// Slice-serial NOR/XOR/ADD/SUB ALU: processes SLICE bits per cycle, carrying between slices in a register.
// Latency: done pulses N = WIDTH/SLICE cycles after the accepting edge; one result per N+1 cycles.
// Backpressure: start is ignored while busy; start during the done cycle is accepted.
module alu_multicycle #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]    LAST  = IW'(N - 1);
    localparam logic [WIDTH-1:0] SMASK = WIDTH'({SLICE{1'b1}});

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [1:0]        op_q;
    logic              carry_q;
    logic [IW-1:0]     idx_q;
    logic              accept;

    logic [SLICE-1:0]  a_sl, b_sl, bx_sl, logic_res, res;
    logic [SLICE:0]    sum_ext;
    logic              c_out, c_into_msb;
    logic [WIDTH-1:0]  s_nxt;
    int                off;

    assign accept = (state != RUN) && start;

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE, DONE: state_nxt = start ? RUN : IDLE;
            RUN:        state_nxt = (idx_q == LAST) ? DONE : RUN;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // One narrow slice of the datapath; SUB is ADD of the inverted operand.
    always_comb begin
        off        = SLICE * int'(idx_q);
        a_sl       = SLICE'(a_q >> off);
        b_sl       = SLICE'(b_q >> off);
        bx_sl      = op_q[0] ? ~b_sl : b_sl;
        sum_ext    = {1'b0, a_sl} + {1'b0, bx_sl} + {{SLICE{1'b0}}, carry_q};
        logic_res  = op_q[0] ? (a_sl ^ b_sl) : ~(a_sl | b_sl);
        res        = op_q[1] ? sum_ext[SLICE-1:0] : logic_res;
        c_out      = op_q[1] & sum_ext[SLICE];
        c_into_msb = a_sl[SLICE-1] ^ bx_sl[SLICE-1] ^ sum_ext[SLICE-1];
        s_nxt      = (s & ~(SMASK << off)) | (WIDTH'(res) << off);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s       <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                op_q    <= op;
                carry_q <= cin;
                idx_q   <= '0;
            end else if (state == RUN) begin
                s       <= s_nxt;
                carry_q <= c_out;
                if (idx_q != LAST) begin
                    idx_q <= idx_q + 1'b1;
                end else begin
                    cout <= c_out;
                    ovf  <= op_q[1] & (c_into_msb ^ sum_ext[SLICE]);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: three configurations (64/16, 64/64, 32/8) driven from shared stimulus
// and checked every cycle against a transaction-level reference model.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst_n, start, cin;
    logic [63:0] a, b;
    logic [1:0]  op;

    logic        busy0, done0, cout0, ovf0;
    logic [63:0] s0;
    logic        busy1, done1, cout1, ovf1;
    logic [63:0] s1;
    logic        busy2, done2, cout2, ovf2;
    logic [31:0] s2;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    localparam int NN[3] = '{4, 1, 4};
    localparam int WW[3] = '{64, 64, 32};

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(64), .SLICE(16)) d0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op), .cin(cin),
        .busy(busy0), .done(done0), .s(s0), .cout(cout0), .ovf(ovf0));

    alu_multicycle #(.WIDTH(64), .SLICE(64)) d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op), .cin(cin),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1));

    alu_multicycle #(.WIDTH(32), .SLICE(8)) d2 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a[31:0]), .b(b[31:0]), .op(op), .cin(cin),
        .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2));

    logic        bsy[3], dn[3], co[3], ov[3];
    logic [63:0] so[3];
    assign bsy[0] = busy0; assign dn[0] = done0; assign co[0] = cout0; assign ov[0] = ovf0; assign so[0] = s0;
    assign bsy[1] = busy1; assign dn[1] = done1; assign co[1] = cout1; assign ov[1] = ovf1; assign so[1] = s1;
    assign bsy[2] = busy2; assign dn[2] = done2; assign co[2] = cout2; assign ov[2] = ovf2; assign so[2] = {32'd0, s2};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Whole-word reference: returns {ovf, cout, s}.
    function automatic logic [65:0] ref_op(input logic [63:0] ra, input logic [63:0] rb,
                                           input logic [1:0] rop, input logic rci, input int w);
        logic [64:0] mask, aa, bb, r;
        logic        c, v;
        mask = (65'd1 << w) - 65'd1;
        aa   = {1'b0, ra} & mask;
        bb   = {1'b0, rb} & mask;
        if (rop == 2'd3) bb = ~bb & mask;
        case (rop)
            2'd0:    r = ~(aa | bb) & mask;
            2'd1:    r = aa ^ bb;
            default: r = aa + bb + {64'd0, rci};
        endcase
        c = rop[1] ? r[w] : 1'b0;
        v = rop[1] && (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
        return {v, c, r[63:0] & mask[63:0]};
    endfunction

    // Model: a remaining-cycle count per instance and the pending result.
    int          rem[3];
    logic        done_e[3], co_e[3], ov_e[3];
    logic [63:0] s_e[3];
    logic [65:0] pend[3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                rem[k] = 0; done_e[k] = 1'b0; s_e[k] = '0; co_e[k] = 1'b0; ov_e[k] = 1'b0;
            end else begin
                done_e[k] = 1'b0;
                if (rem[k] > 0) begin
                    rem[k]--;
                    if (rem[k] == 0) begin
                        done_e[k] = 1'b1;
                        {ov_e[k], co_e[k], s_e[k]} = pend[k];
                    end
                end else if (start) begin
                    rem[k]  = NN[k];
                    pend[k] = ref_op(a, b, op, cin, WW[k]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("d%0d busy", k), 64'(bsy[k]), 64'(rem[k] > 0));
                chk($sformatf("d%0d done", k), 64'(dn[k]), 64'(done_e[k]));
                if (rem[k] == 0) begin
                    chk($sformatf("d%0d s", k), so[k], s_e[k]);
                    chk($sformatf("d%0d cout", k), 64'(co[k]), 64'(co_e[k]));
                    chk($sformatf("d%0d ovf", k), 64'(ov[k]), 64'(ov_e[k]));
                end
            end
        end
    end

    task automatic rnd_ops();
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        op  = 2'($urandom_range(0, 3));
        cin = 1'($urandom_range(0, 1));
    endtask

    // One transaction on the default instance with literal expectations; operands churn while busy.
    task automatic direct(input string nm, input logic [63:0] ta, input logic [63:0] tb_v,
                          input logic [1:0] top, input logic tci,
                          input logic [63:0] es, input logic ec, input logic ev);
        int cyc;
        @(negedge clk);
        a = ta; b = tb_v; op = top; cin = tci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done0 && cyc < 20) begin
            rnd_ops();
            @(negedge clk);
            cyc++;
        end
        chk({nm, " latency"}, 64'(cyc), 64'd4);
        chk({nm, " s"}, s0, es);
        chk({nm, " cout"}, 64'(cout0), 64'(ec));
        chk({nm, " ovf"}, 64'(ovf0), 64'(ev));
    endtask

    initial begin
        int ndone;
        int at[2];
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy0), 64'd0);
        chk("reset done", 64'(done0), 64'd0);
        chk("reset s", s0, 64'd0);
        chk("reset cout", 64'(cout0), 64'd0);
        chk("reset ovf", 64'(ovf0), 64'd0);
        rst_n = 1'b1;
        check_en = 1'b1;

        direct("add ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        direct("add ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2'b10, 1'b1, 64'd0, 1'b1, 1'b0);
        direct("sub 5-7", 64'd5, 64'd7, 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        direct("sub ovf", 64'h8000_0000_0000_0000, 64'd1, 2'b11, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        direct("nor", 64'hF0F0_0000_0000_0000, 64'h0F00_0000_0000_00FF, 2'b00, 1'b0,
               64'h000F_FFFF_FFFF_FF00, 1'b0, 1'b0);
        direct("xor", 64'hF0F0_0000_0000_0000, 64'h0F00_0000_0000_00FF, 2'b01, 1'b0,
               64'hFFF0_0000_0000_00FF, 1'b0, 1'b0);

        // start held for 10 edges: accepts at +0 and in the done cycle at +5.
        @(negedge clk);
        rnd_ops();
        start = 1'b1;
        ndone = 0;
        at[0] = -1; at[1] = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done0) begin
                if (ndone < 2) at[ndone] = k;
                ndone++;
            end
            rnd_ops();
        end
        start = 1'b0;
        chk("b2b done count", 64'(ndone), 64'd2);
        chk("b2b first done", 64'(at[0]), 64'd4);
        chk("b2b second done", 64'(at[1]), 64'd9);
        repeat (6) @(negedge clk);

        // Reset during the second RUN cycle aborts without a done pulse.
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = '0; op = 2'b10; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort busy", 64'(busy0), 64'd0);
        chk("abort done", 64'(done0), 64'd0);
        chk("abort s", s0, 64'd0);
        chk("abort cout", 64'(cout0), 64'd0);
        rst_n = 1'b1;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        chk("abort no done", 64'(ndone), 64'd0);
        direct("after abort", 64'h0000_0000_FFFF_FFFF, 64'd1, 2'b10, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rnd_ops();
            start = ($urandom_range(0, 2) == 0);
            rst_n = ($urandom_range(0, 149) != 0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
